// File: rtl/pll_drp_resp.sv
// Behavioural stand-in for the PLL_ADV DRP slave: register file, DRDY latency,
// RST/LOCKED sequencing and a sticky flag for master protocol violations.
module pll_drp_resp #(
  parameter int AW       = 5,
  parameter int DW       = 16,
  parameter int DRDY_LAT = 3,
  parameter int LOCK_CYC = 64
) (
  input  logic          CLK,
  input  logic          RSTXO,
  input  logic          DEN,
  input  logic          DWE,
  input  logic [AW-1:0] DADDR,
  input  logic [DW-1:0] DI,
  output logic [DW-1:0] DO,
  output logic          DRDY,
  input  logic          RST_PLL,
  output logic          LOCKED,
  output logic          ERR,
  output logic [7:0]    WR_CNT
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [3:0]  LAT_LOAD = 4'(DRDY_LAT - 1);
  localparam logic [15:0] LOCK_MAX = 16'(LOCK_CYC);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      lat_cnt_q;
  logic [AW-1:0]   addr_q;
  logic            dwe_q;
  logic [DW-1:0]   di_q;
  logic [DW-1:0]   rf_q [DEPTH];
  logic [15:0]     lock_cnt_q;

  logic            accept;
  logic            complete;
  logic            overlap;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    overlap  = 1'b0;
    case (state_q)
      IDLE: begin
        if (DEN) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        overlap = DEN;
        if (lat_cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      dwe_q     <= 1'b0;
      di_q      <= '0;
      DRDY      <= 1'b0;
      DO        <= '0;
      WR_CNT    <= '0;
      ERR       <= 1'b0;
    end else begin
      state_q <= state_d;
      DRDY    <= complete;
      DO      <= (complete && !dwe_q) ? rf_q[addr_q] : '0;

      if (accept) begin
        addr_q    <= DADDR;
        dwe_q     <= DWE;
        di_q      <= DI;
        lat_cnt_q <= LAT_LOAD;
      end else if (state_q == BUSY && lat_cnt_q != 4'd0) begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
      end

      if (complete && dwe_q)
        WR_CNT <= WR_CNT + 8'd1;

      // Reconfiguration writes are only legal while the PLL is held in reset.
      if (overlap || (complete && dwe_q && !RST_PLL))
        ERR <= 1'b1;
    end
  end

  // NOTE: the register file is reset explicitly because the emulated PLL powers up with zeroed DRP registers.
  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      for (int i = 0; i < DEPTH; i++)
        rf_q[i] <= '0;
    end else if (complete && dwe_q) begin
      rf_q[addr_q] <= di_q;
    end
  end

  // Lock emulation: LOCKED follows one edge after the counter reaches LOCK_CYC.
  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      lock_cnt_q <= '0;
      LOCKED     <= 1'b0;
    end else if (RST_PLL) begin
      lock_cnt_q <= '0;
      LOCKED     <= 1'b0;
    end else begin
      if (lock_cnt_q != LOCK_MAX)
        lock_cnt_q <= lock_cnt_q + 16'd1;
      LOCKED <= (lock_cnt_q == LOCK_MAX);
    end
  end

endmodule

// File: tb/tb_pll_drp_resp.sv
// Self-checking bench for pll_drp_resp: directed plan steps plus random traffic,
// every output compared each cycle against a transaction-level reference model.
module tb_pll_drp_resp;

  localparam int AW   = 5;
  localparam int DW   = 16;
  localparam int LAT  = 3;
  localparam int LOCK = 64;

  logic          CLK     = 1'b0;
  logic          RSTXO   = 1'b1;
  logic          DEN     = 1'b0;
  logic          DWE     = 1'b0;
  logic [AW-1:0] DADDR   = '0;
  logic [DW-1:0] DI      = '0;
  logic          RST_PLL = 1'b1;
  logic [DW-1:0] DO;
  logic          DRDY;
  logic          LOCKED;
  logic          ERR;
  logic [7:0]    WR_CNT;

  pll_drp_resp #(.AW(AW), .DW(DW), .DRDY_LAT(LAT), .LOCK_CYC(LOCK)) dut (
    .CLK(CLK), .RSTXO(RSTXO), .DEN(DEN), .DWE(DWE), .DADDR(DADDR), .DI(DI),
    .DO(DO), .DRDY(DRDY), .RST_PLL(RST_PLL), .LOCKED(LOCKED), .ERR(ERR), .WR_CNT(WR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one pending transaction described by the edge it completes on.
  logic [DW-1:0] m_mem [2**AW];
  bit            m_pend;
  int            m_done;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_edge;
  int            m_since;
  bit            m_err;
  int            m_wr_cnt;
  logic [DW-1:0] e_do;
  bit            e_drdy;
  bit            e_locked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    m_pend = 0; m_done = 0; m_edge = 0; m_since = 0; m_err = 0; m_wr_cnt = 0;
    e_do = '0; e_drdy = 0; e_locked = 0;
  endfunction

  function automatic void model_edge();
    bit was_free;
    was_free = !m_pend;
    m_edge++;
    e_drdy = 0;
    e_do   = '0;
    if (m_pend && m_edge == m_done) begin
      e_drdy = 1;
      if (m_wr) begin
        m_mem[m_addr] = m_data;
        m_wr_cnt = (m_wr_cnt + 1) % 256;
        if (!RST_PLL) m_err = 1;
      end else begin
        e_do = m_mem[m_addr];
      end
      m_pend = 0;
    end
    if (DEN) begin
      if (was_free) begin
        m_pend = 1; m_done = m_edge + LAT; m_wr = DWE; m_addr = DADDR; m_data = DI;
      end else begin
        m_err = 1;
      end
    end
    if (RST_PLL) m_since = 0;
    else if (m_since < LOCK + 1) m_since++;
    e_locked = (m_since >= LOCK + 1);
  endfunction

  task automatic check_outputs();
    check("do",     32'(DO),     32'(e_do));
    check("drdy",   32'(DRDY),   32'(e_drdy));
    check("locked", 32'(LOCKED), 32'(e_locked));
    check("err",    32'(ERR),    32'(m_err));
    check("wr_cnt", 32'(WR_CNT), 32'(m_wr_cnt));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    DEN   = 1'b0;
    RSTXO = 1'b0;
    #1;
    model_clear();
    check_outputs();
    repeat (2) @(posedge CLK);
    #1;
    RSTXO = 1'b1;
  endtask

  task automatic drp(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    DEN = 1'b1; DWE = we; DADDR = a; DI = d;
    step();
    DEN = 1'b0; DWE = 1'b0;
  endtask

  task automatic wait_drdy(input int max, output int edges, output logic [DW-1:0] d);
    edges = 0;
    while (!DRDY && edges < max) begin
      step();
      edges++;
    end
    if (!DRDY) begin
      n_checks++;
      n_fail++;
      $error("FAIL drdy_timeout observed=no_drdy expected=drdy_within_%0d", max);
    end
    d = DO;
  endtask

  task automatic count_lock(input string tag);
    int e;
    e = 0;
    while (!LOCKED && e < 200) begin
      step();
      e++;
    end
    check(tag, 32'(e), 32'(LOCK + 1));
  endtask

  initial begin
    int            e;
    logic [DW-1:0] d;

    #2;
    // 1: reset, RST_PLL high for 10 cycles, then lock after 65 edges
    RST_PLL = 1'b1;
    apply_reset();
    repeat (10) step();
    RST_PLL = 1'b0;
    count_lock("lock_edges");

    // 5b: pulse RST_PLL while locked
    RST_PLL = 1'b1;
    step();
    check("unlock_next_edge", 32'(LOCKED), 32'd0);
    RST_PLL = 1'b0;
    count_lock("relock_edges");

    // 2: write then read with PLL in reset
    RST_PLL = 1'b1;
    drp(1'b1, 5'h08, 16'hA5C3);
    wait_drdy(10, e, d);
    check("wr_lat", 32'(e), 32'(LAT));
    check("wr_cnt_1", 32'(WR_CNT), 32'd1);
    step();
    drp(1'b0, 5'h08, 16'h0);
    wait_drdy(10, e, d);
    check("rd_lat", 32'(e), 32'(LAT));
    check("rd_data", 32'(d), 32'h0000A5C3);
    check("err_clean", 32'(ERR), 32'd0);

    // 3: read of never-written address
    step();
    drp(1'b0, 5'h1F, 16'h0);
    wait_drdy(10, e, d);
    check("rd_unwritten", 32'(d), 32'd0);
    step();

    // 4: overlapping DEN, then DEN coincident with DRDY
    drp(1'b1, 5'h03, 16'h1111);
    drp(1'b0, 5'h04, 16'h0);
    wait_drdy(10, e, d);
    check("overlap_lat", 32'(e), 32'(LAT - 1));
    check("err_overlap", 32'(ERR), 32'd1);
    drp(1'b0, 5'h03, 16'h0);
    wait_drdy(10, e, d);
    check("b2b_lat", 32'(e), 32'(LAT));
    check("b2b_data", 32'(d), 32'h00001111);
    step();

    // 5a: write while PLL running flags ERR but still lands
    apply_reset();
    RST_PLL = 1'b0;
    drp(1'b1, 5'h02, 16'h1234);
    wait_drdy(10, e, d);
    check("err_wr_running", 32'(ERR), 32'd1);
    drp(1'b0, 5'h02, 16'h0);
    wait_drdy(10, e, d);
    check("rd_1234", 32'(d), 32'h00001234);
    step();

    // 6: reset one cycle after a write's DEN discards it
    RST_PLL = 1'b1;
    drp(1'b1, 5'h08, 16'hBEEF);
    apply_reset();
    repeat (5) step();
    drp(1'b0, 5'h08, 16'h0);
    wait_drdy(10, e, d);
    check("rd_after_abort", 32'(d), 32'd0);
    check("wr_cnt_abort", 32'(WR_CNT), 32'd0);
    step();

    // 256 back-to-back writes wrap WR_CNT
    for (int i = 0; i < 256; i++) begin
      drp(1'b1, AW'(i), DW'(i * 16'h0101));
      wait_drdy(10, e, d);
    end
    check("wr_cnt_wrap", 32'(WR_CNT), 32'd0);
    step();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) RST_PLL = ~RST_PLL;
      DEN   = ($urandom_range(0, 2) == 0);
      DWE   = 1'($urandom);
      DADDR = AW'($urandom);
      DI    = DW'($urandom);
      step();
      DEN = 1'b0;
    end
    repeat (LAT + 2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
